ctrl_tx: RTL and testbench
==========================

# ctrl_tx

Transmit-side system controller: collects register-file read data and ALU results, serialises them into a byte stream and hands each byte to the UART transmitter with a valid/busy handshake. Sits between the register file/ALU and the UART TX, mirroring the receive-side command decoder that feeds them. Both sources are buffered one-deep, so a response is never lost while a previous frame is still being sent.

## Interface
- `WIDTH`, 8: byte width; the register data width.
- `ALU_W`, 16 (2*WIDTH): ALU result width; must be a multiple of `WIDTH`.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `RdData` in WIDTH: register-file read data.
- `RdData_VLD` in 1: 1-cycle strobe; `RdData` valid.
- `ALU_OUT` in ALU_W: ALU result.
- `ALU_OUT_VLD` in 1: 1-cycle strobe; `ALU_OUT` valid.
- `TX_BUSY` in 1: UART TX is shifting a byte.
- `TX_P_DATA` out WIDTH: byte to transmit, registered.
- `TX_D_VLD` out 1: `TX_P_DATA` valid, registered.
- `clk_div_en` out 1: UART clock divider enable, registered.
- `overrun` out 1: 1-cycle pulse when a strobe arrives while that source's slot is full.

## Operation
- **Holding slots.** There are two slots, `rd_slot` (WIDTH bits plus a full flag) and `alu_slot` (ALU_W bits plus a full flag).
  - A strobe while the slot is empty loads the slot and sets full.
  - A strobe while the slot is full drops the new data, leaves the slot unchanged and pulses `overrun`.
  - A slot clears on the cycle its last byte is accepted. A new strobe in that same cycle loads the slot and is not an overrun.
- **Arbitration in IDLE.** If both slots are full, `alu_slot` wins and `rd_slot` waits.
- **Frames.**
  - A read frame is 1 byte: `RdData`.
  - An ALU frame is ALU_W/WIDTH bytes, least-significant byte first.
  - A checksum byte is appended when configured (see Configuration).
- **FSM states:** IDLE, LOAD, SEND, WAIT_FREE.
  - IDLE → LOAD when any slot is full. The FSM latches the source and resets the byte index to 0.
  - LOAD → SEND: drives `TX_P_DATA` with the selected byte and asserts `TX_D_VLD`.
  - SEND holds `TX_D_VLD` high with stable data until `TX_BUSY` is sampled high (accept), then deasserts `TX_D_VLD` and moves to WAIT_FREE.
  - WAIT_FREE waits until `TX_BUSY` is sampled low. It then goes to LOAD if bytes remain, otherwise clears the slot and returns to IDLE.
- **Byte index.** The index counter is sized with $clog2 of (ALU_W/WIDTH + 1). It never wraps mid-frame and is reset on entry to LOAD from IDLE.
- **clk_div_en** is 0 in reset and 1 from the first clock edge after reset release, held constant.
- **Reset mid-frame.** Reset asynchronously forces IDLE and clears both slots. The partial frame is abandoned and is not resumed.

## Timing
- Reset values: `TX_P_DATA`=0, `TX_D_VLD`=0, `clk_div_en`=0, `overrun`=0; internal state is IDLE with both slots empty.
- A strobe is sampled at edge N. The slot is full after edge N, LOAD is entered at N+1, and `TX_D_VLD` is high after edge N+2 (2-cycle latency from an idle FSM).
- `overrun` is high for exactly the cycle after the offending strobe edge.
- Accept: `TX_D_VLD` falls on the edge after `TX_BUSY` is first sampled high.
- Minimum gap between bytes: 2 cycles after `TX_BUSY` falls (WAIT_FREE→LOAD→SEND).
- If `TX_BUSY` is already high in IDLE, SEND treats it as an accept. Integrators must guarantee that `TX_BUSY` is low when no byte is offered.

## Configuration
- **`CTRL_TX_CHKSUM_EN` defined:** every frame is followed by one extra byte, the XOR of all payload bytes of that frame. The byte index then runs to the payload length inclusive.
- **Not defined:** frames carry only payload bytes and there is no checksum logic.

## Structure
- Shared package `ctrl_tx_pkg` holds:
  - the state typedef, encoded IDLE=2'b00, LOAD=2'b01, SEND=2'b10, WAIT_FREE=2'b11;
  - the source enum (SRC_RD, SRC_ALU);
  - the localparam `ALU_BYTES` = ALU_W/WIDTH.
- One sub-module, `ctrl_tx_slot`: a parameterised-width holding register with full flag, load, clear and overrun pulse. It is instantiated twice.

## Test plan
- **Reset:** hold `RST` low, then release → all outputs 0 during reset; `clk_div_en`=1 one cycle after release; `TX_D_VLD` stays 0.
- **Register read:** `RdData`=8'hA5 strobed, TX_BUSY modelled 3 cycles after accept → one byte 8'hA5. With `CTRL_TX_CHKSUM_EN` defined, a second byte 8'hA5 follows.
- **ALU frame:** `ALU_OUT`=16'h1234 strobed → bytes 8'h34 then 8'h12. With `CTRL_TX_CHKSUM_EN` defined, a third byte 8'h26 follows.
- **Simultaneous strobes:** `RdData`=8'h0F and `ALU_OUT`=16'hBEEF in the same cycle → bytes EF, BE, then 0F; `overrun` stays 0.
- **Overrun:** two `RdData` strobes (8'h11 then 8'h22) while the first frame is stalled by TX_BUSY high → `overrun` pulses once; only 8'h11 is sent.
- **Reset mid-frame:** assert `RST` after the first byte of 16'hCAFE is accepted → `TX_D_VLD` is 0 immediately; after release no further bytes are sent.

Source files
------------

// File: rtl/ctrl_tx_pkg.sv
// ctrl_tx_pkg: shared types and constants for the transmit-side controller.
//   state_e   - FSM state encoding (IDLE, LOAD, SEND, WAIT_FREE)
//   src_e     - frame source (register read or ALU result)
//   ALU_BYTES - bytes per ALU frame for the default widths
// Optional feature macro used by the design: CTRL_TX_CHKSUM_EN.
package ctrl_tx_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_ALU_W = 2 * DEF_WIDTH;
  localparam int unsigned ALU_BYTES = DEF_ALU_W / DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD      = 2'b01,
    SEND      = 2'b10,
    WAIT_FREE = 2'b11
  } state_e;

  typedef enum logic {
    SRC_RD  = 1'b0,
    SRC_ALU = 1'b1
  } src_e;

endpackage

// File: rtl/ctrl_tx_if.sv
// ctrl_tx_if: bundles the source strobes, UART TX handshake and status outputs.
//   master - the controller side (consumes source data and TX_BUSY, drives the TX byte)
//   slave  - the environment side (register file, ALU and UART TX)
// Signals: RdData/RdData_VLD, ALU_OUT/ALU_OUT_VLD, TX_BUSY, TX_P_DATA, TX_D_VLD,
//          clk_div_en, overrun.
interface ctrl_tx_if
  import ctrl_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ALU_W = DEF_ALU_W
);

  logic [WIDTH-1:0] RdData;
  logic             RdData_VLD;
  logic [ALU_W-1:0] ALU_OUT;
  logic             ALU_OUT_VLD;
  logic             TX_BUSY;
  logic [WIDTH-1:0] TX_P_DATA;
  logic             TX_D_VLD;
  logic             clk_div_en;
  logic             overrun;

  modport master (
    input  RdData, RdData_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output TX_P_DATA, TX_D_VLD, clk_div_en, overrun
  );

  modport slave (
    output RdData, RdData_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  TX_P_DATA, TX_D_VLD, clk_div_en, overrun
  );

endinterface

// File: rtl/ctrl_tx_slot.sv
// ctrl_tx_slot: one-deep holding register with full flag.
//   CLK, RST  - clock, asynchronous active-low reset
//   load, din - 1-cycle strobe and its data
//   clr       - frame finished; frees the slot (a same-cycle load refills it)
//   dout      - held data
//   full      - slot occupied
//   overrun   - registered 1-cycle pulse: a load arrived while the slot stayed full
module ctrl_tx_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;
  logic             ovr_q, ovr_d;
  logic             free;

  always_comb begin
    // A slot being cleared this cycle counts as free for an incoming strobe.
    free   = ~full_q | clr;
    data_d = data_q;
    full_d = full_q;
    ovr_d  = 1'b0;
    if (load && free) begin
      data_d = din;
      full_d = 1'b1;
    end else if (clr) begin
      full_d = 1'b0;
    end
    if (load && !free) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q <= '0;
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      ovr_q  <= ovr_d;
    end
  end

  assign dout    = data_q;
  assign full    = full_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/ctrl_tx.sv
// ctrl_tx: transmit-side controller. Buffers register-read data and ALU results one-deep
// and serialises them, LSB byte first, to the UART TX over a valid/busy handshake.
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-low reset
//   bus  - ctrl_tx_if master: RdData/RdData_VLD, ALU_OUT/ALU_OUT_VLD, TX_BUSY in;
//          TX_P_DATA, TX_D_VLD, clk_div_en, overrun out
// Build option: define CTRL_TX_CHKSUM_EN to append an XOR checksum byte to every frame.
module ctrl_tx
  import ctrl_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ALU_W = DEF_ALU_W
) (
  input logic        CLK,
  input logic        RST,
  ctrl_tx_if.master  bus
);

  localparam int unsigned NBYTES = ALU_W / WIDTH;
`ifdef CTRL_TX_CHKSUM_EN
  localparam int unsigned EXTRA = 1;
`else
  localparam int unsigned EXTRA = 0;
`endif
  localparam int unsigned IDX_W = $clog2(NBYTES + 1);

  // Holding slots
  logic             rd_full, alu_full;
  logic             rd_clr, alu_clr;
  logic             rd_ovr, alu_ovr;
  logic [WIDTH-1:0] rd_data;
  logic [ALU_W-1:0] alu_data;

  ctrl_tx_slot #(.WIDTH(WIDTH)) u_rd_slot (
    .CLK     (CLK),
    .RST     (RST),
    .load    (bus.RdData_VLD),
    .din     (bus.RdData),
    .clr     (rd_clr),
    .dout    (rd_data),
    .full    (rd_full),
    .overrun (rd_ovr)
  );

  ctrl_tx_slot #(.WIDTH(ALU_W)) u_alu_slot (
    .CLK     (CLK),
    .RST     (RST),
    .load    (bus.ALU_OUT_VLD),
    .din     (bus.ALU_OUT),
    .clr     (alu_clr),
    .dout    (alu_data),
    .full    (alu_full),
    .overrun (alu_ovr)
  );

  // FSM and output registers
  state_e           state_q, state_d;
  src_e             src_q, src_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_vld_q, tx_vld_d;
  logic             div_en_q;

  logic [WIDTH-1:0] alu_byte, payload_byte, cur_byte;
  logic [IDX_W-1:0] frame_last;

  always_comb begin
    alu_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        alu_byte = alu_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign payload_byte = (src_q == SRC_ALU) ? alu_byte : rd_data;
  assign frame_last   = (src_q == SRC_ALU) ? IDX_W'(NBYTES - 1 + EXTRA) : IDX_W'(EXTRA);

`ifdef CTRL_TX_CHKSUM_EN
  logic [WIDTH-1:0] chk;

  always_comb begin
    chk = '0;
    if (src_q == SRC_ALU) begin
      for (int i = 0; i < NBYTES; i++) begin
        chk = chk ^ alu_data[i*WIDTH +: WIDTH];
      end
    end else begin
      chk = rd_data;
    end
  end

  // The final index of every frame carries the checksum instead of payload.
  assign cur_byte = (idx_q == frame_last) ? chk : payload_byte;
`else
  assign cur_byte = payload_byte;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    rd_clr    = 1'b0;
    alu_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (alu_full) begin
          src_d   = SRC_ALU;
          idx_d   = '0;
          state_d = LOAD;
        end else if (rd_full) begin
          src_d   = SRC_RD;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = cur_byte;
        tx_vld_d  = 1'b1;
        state_d   = SEND;
      end
      SEND: begin
        if (bus.TX_BUSY) begin
          tx_vld_d = 1'b0;
          state_d  = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        if (!bus.TX_BUSY) begin
          if (idx_q == frame_last) begin
            rd_clr  = (src_q == SRC_RD);
            alu_clr = (src_q == SRC_ALU);
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      src_q     <= SRC_RD;
      idx_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      div_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      div_en_q  <= 1'b1;
    end
  end

  assign bus.TX_P_DATA  = tx_data_q;
  assign bus.TX_D_VLD   = tx_vld_q;
  assign bus.clk_div_en = div_en_q;
  assign bus.overrun    = rd_ovr | alu_ovr;

endmodule

// File: tb/tb_ctrl_tx.sv
// tb_ctrl_tx: self-checking bench for ctrl_tx. A UART TX model accepts each offered byte,
// holds TX_BUSY for 3 cycles and checks the byte against a scoreboard queue filled when
// the strobes are driven.
module tb_ctrl_tx;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 16;
`ifdef CTRL_TX_CHKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  ctrl_tx_if #(.WIDTH(W), .ALU_W(AW)) bus ();

  ctrl_tx #(.WIDTH(W), .ALU_W(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         rx_count = 0;
  int         ovr_seen = 0;
  int         vld_seen = 0;
  int         busy_cnt = 0;
  logic       hold_busy = 1'b0;
  logic [7:0] exp_q[$];

  // UART TX model and scoreboard checker
  initial begin
    logic [7:0] e;
    bus.TX_BUSY = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus.overrun === 1'b1) ovr_seen++;
      if (bus.TX_D_VLD === 1'b1) vld_seen++;
      if (!RST) begin
        bus.TX_BUSY = 1'b0;
        busy_cnt    = 0;
      end else if (bus.TX_BUSY) begin
        if (!hold_busy) begin
          if (busy_cnt > 1) busy_cnt--;
          else begin
            busy_cnt    = 0;
            bus.TX_BUSY = 1'b0;
          end
        end
      end else if (bus.TX_D_VLD === 1'b1) begin
        rx_count++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_byte: got %h, required no byte", bus.TX_P_DATA);
        end else begin
          e = exp_q.pop_front();
          if (bus.TX_P_DATA !== e) begin
            n_fail++;
            $display("FAIL tx_byte: got %h, required %h", bus.TX_P_DATA, e);
          end
        end
        bus.TX_BUSY = 1'b1;
        busy_cnt    = 3;
      end
    end
  end

  task automatic strobe_rd(input logic [7:0] d);
    @(negedge CLK);
    bus.RdData     = d;
    bus.RdData_VLD = 1'b1;
    exp_q.push_back(d);
    if (EXTRA != 0) exp_q.push_back(d);
    @(negedge CLK);
    bus.RdData_VLD = 1'b0;
  endtask

  task automatic strobe_alu(input logic [15:0] d);
    @(negedge CLK);
    bus.ALU_OUT     = d;
    bus.ALU_OUT_VLD = 1'b1;
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
    if (EXTRA != 0) exp_q.push_back(d[7:0] ^ d[15:8]);
    @(negedge CLK);
    bus.ALU_OUT_VLD = 1'b0;
  endtask

  // Waits until every expected byte arrived and the link stayed quiet for 8 cycles.
  task automatic drain(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      if (exp_q.size() == 0 && !bus.TX_BUSY && !bus.TX_D_VLD) quiet++;
      else quiet = 0;
      if (quiet >= 8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int v0;
    bus.RdData      = '0;
    bus.RdData_VLD  = 1'b0;
    bus.ALU_OUT     = '0;
    bus.ALU_OUT_VLD = 1'b0;
    RST             = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (bus.TX_P_DATA !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx_p_data: got %h, required 00", bus.TX_P_DATA);
    end
    n_checks++;
    if (bus.TX_D_VLD !== 1'b0) begin
      n_fail++; $display("FAIL reset_tx_d_vld: got %b, required 0", bus.TX_D_VLD);
    end
    n_checks++;
    if (bus.clk_div_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_clk_div_en: got %b, required 0", bus.clk_div_en);
    end
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun: got %b, required 0", bus.overrun);
    end
    @(negedge CLK);
    RST = 1'b1;
    v0  = vld_seen;
    #1;
    n_checks++;
    if (bus.clk_div_en !== 1'b0) begin
      n_fail++; $display("FAIL div_en_before_edge: got %b, required 0", bus.clk_div_en);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.clk_div_en !== 1'b1) begin
      n_fail++; $display("FAIL div_en_after_release: got %b, required 1", bus.clk_div_en);
    end
    repeat (6) @(posedge CLK);
    #1;
    n_checks++;
    if (vld_seen != v0 || bus.TX_D_VLD !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_valid: got %0d valid cycles, required 0", vld_seen - v0);
    end
  endtask

  task automatic test_rd_read();
    bit ok;
    int r0;
    r0 = rx_count;
    @(negedge CLK);
    bus.RdData     = 8'hA5;
    bus.RdData_VLD = 1'b1;
    exp_q.push_back(8'hA5);
    if (EXTRA != 0) exp_q.push_back(8'hA5);
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.TX_D_VLD !== 1'b0) begin
      n_fail++; $display("FAIL rd_latency_n: got %b, required 0", bus.TX_D_VLD);
    end
    @(negedge CLK);
    bus.RdData_VLD = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.TX_D_VLD !== 1'b0) begin
      n_fail++; $display("FAIL rd_latency_n1: got %b, required 0", bus.TX_D_VLD);
    end
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== 8'hA5) begin
      n_fail++;
      $display("FAIL rd_latency_n2: got vld=%b data=%h, required vld=1 data=a5",
               bus.TX_D_VLD, bus.TX_P_DATA);
    end
    drain(200, ok);
    n_checks++;
    if (!ok || rx_count - r0 != 1 + EXTRA) begin
      n_fail++;
      $display("FAIL rd_frame: got %0d bytes (drained=%0d), required %0d",
               rx_count - r0, ok, 1 + EXTRA);
    end
  endtask

  task automatic test_alu_frame();
    bit ok;
    int r0;
    r0 = rx_count;
    strobe_alu(16'h1234);
    drain(300, ok);
    n_checks++;
    if (!ok || rx_count - r0 != 2 + EXTRA) begin
      n_fail++;
      $display("FAIL alu_frame: got %0d bytes (drained=%0d), required %0d",
               rx_count - r0, ok, 2 + EXTRA);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int r0, o0;
    r0 = rx_count;
    o0 = ovr_seen;
    @(negedge CLK);
    bus.RdData      = 8'h0F;
    bus.RdData_VLD  = 1'b1;
    bus.ALU_OUT     = 16'hBEEF;
    bus.ALU_OUT_VLD = 1'b1;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    if (EXTRA != 0) exp_q.push_back(8'h51);
    exp_q.push_back(8'h0F);
    if (EXTRA != 0) exp_q.push_back(8'h0F);
    @(negedge CLK);
    bus.RdData_VLD  = 1'b0;
    bus.ALU_OUT_VLD = 1'b0;
    drain(500, ok);
    n_checks++;
    if (!ok || rx_count - r0 != 3 + 2 * EXTRA) begin
      n_fail++;
      $display("FAIL simult_frames: got %0d bytes (drained=%0d), required %0d",
               rx_count - r0, ok, 3 + 2 * EXTRA);
    end
    n_checks++;
    if (ovr_seen != o0) begin
      n_fail++; $display("FAIL simult_overrun: got %0d pulses, required 0", ovr_seen - o0);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int r0, o0;
    r0        = rx_count;
    hold_busy = 1'b1;
    strobe_rd(8'h11);
    for (int i = 0; i < 50 && rx_count == r0; i++) @(posedge CLK);
    n_checks++;
    if (rx_count == r0) begin
      n_fail++; $display("FAIL ovr_first_accept: got 0 bytes, required 1");
    end
    repeat (2) @(posedge CLK);
    o0 = ovr_seen;
    @(negedge CLK);
    bus.RdData     = 8'h22;
    bus.RdData_VLD = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_pulse: got %b, required 1", bus.overrun);
    end
    @(negedge CLK);
    bus.RdData_VLD = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++;
    if (bus.overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_pulse_end: got %b, required 0", bus.overrun);
    end
    repeat (5) @(posedge CLK);
    hold_busy = 1'b0;
    drain(300, ok);
    n_checks++;
    if (!ok || rx_count - r0 != 1 + EXTRA) begin
      n_fail++;
      $display("FAIL ovr_frame: got %0d bytes (drained=%0d), required %0d",
               rx_count - r0, ok, 1 + EXTRA);
    end
    n_checks++;
    if (ovr_seen - o0 != 1) begin
      n_fail++; $display("FAIL ovr_count: got %0d pulses, required 1", ovr_seen - o0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int r0, v0;
    r0 = rx_count;
    @(negedge CLK);
    bus.ALU_OUT     = 16'hCAFE;
    bus.ALU_OUT_VLD = 1'b1;
    exp_q.push_back(8'hFE);
    @(negedge CLK);
    bus.ALU_OUT_VLD = 1'b0;
    for (int i = 0; i < 50 && rx_count == r0; i++) @(posedge CLK);
    n_checks++;
    if (rx_count - r0 != 1) begin
      n_fail++; $display("FAIL mid_first_byte: got %0d bytes, required 1", rx_count - r0);
    end
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    n_checks++;
    if (bus.TX_D_VLD !== 1'b0 || bus.TX_P_DATA !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got vld=%b data=%h, required vld=0 data=00",
               bus.TX_D_VLD, bus.TX_P_DATA);
    end
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (bus.clk_div_en !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_div_en: got %b, required 0", bus.clk_div_en);
    end
    @(negedge CLK);
    RST = 1'b1;
    r0  = rx_count;
    v0  = vld_seen;
    repeat (40) @(posedge CLK);
    #1;
    n_checks++;
    if (vld_seen != v0 || rx_count != r0) begin
      n_fail++;
      $display("FAIL mid_abandoned: got %0d valid cycles %0d bytes, required 0 and 0",
               vld_seen - v0, rx_count - r0);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL mid_scoreboard: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rd_read();
    test_alu_frame();
    test_simultaneous();
    test_overrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
